// File: rtl/hsi_s_rx_frame_sched_pkg.sv
// Shared definitions for the HSI slave RX frame scheduler: frame overhead,
// drop reason codes, controller state encoding and small saturating helpers.
package hsi_s_rx_frame_sched_pkg;

  // flag + len + two CRC bytes
  localparam int FRM_OVH = 4;

  localparam logic [2:0] DROP_RX_ERR  = 3'd1;
  localparam logic [2:0] DROP_LEN     = 3'd2;
  localparam logic [2:0] DROP_OVF     = 3'd3;
  localparam logic [2:0] DROP_TIMEOUT = 3'd4;
  localparam logic [2:0] DROP_BUSY    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TAIL    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_HOLD    = 3'd5,
    ST_DROP    = 3'd6
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hsi_s_rx_frame_sched_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write and
// registered read (output register cleared by reset).
module hsi_rx_frame_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= 8'd0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/hsi_s_rx_frame_sched.sv
// Frame-level controller behind the HSI slave RX datapath: parses flag/len,
// buffers payload, commits or drops each frame and serves committed frames.
module hsi_s_rx_frame_sched
  import hsi_s_rx_frame_sched_pkg::*;
#(
  parameter int BUF_DEPTH     = 256,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] d,
  input  logic       d_rdy,
  input  logic       frame_end,
  input  logic [7:0] rx_flag,
  input  logic [5:0] rx_errs,
  output logic       frm_valid,
  output logic [7:0] frm_flag,
  output logic [7:0] frm_len,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  input  logic       frm_ack,
  output logic       err_vld,
  output logic [2:0] err_code,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        state_reg;
  logic [7:0]    len_reg;
  logic [7:0]    flag_reg;
  logic [5:0]    errs_reg;
  logic [15:0]   byte_cnt_reg;
  logic          ovf_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [7:0]    wr_ptr_reg;
  logic [7:0]    rd_ptr_reg;
  logic          rd_zero_reg;
  logic          busy_frm_reg;
  logic          frm_valid_reg;
  logic [7:0]    frm_flag_reg;
  logic [7:0]    frm_len_reg;
  logic          err_vld_reg;
  logic [2:0]    err_code_reg;
  logic [7:0]    drop_cnt_reg;
  logic          busy_reg;

  logic          in_frame;
  logic [15:0]   cnt_next;
  logic [15:0]   len_ext;
  logic          to_hit;
  logic          busy_zone;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [7:0]    ram_q;

  assign in_frame  = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                     (state_reg == ST_TAIL);
  assign cnt_next  = d_rdy ? sat_inc16(byte_cnt_reg) : byte_cnt_reg;
  assign len_ext   = {8'd0, len_reg};
  assign to_hit    = clk_en && !d_rdy && (to_cnt_reg == TW'(TIMEOUT_TICKS - 1));
  // A frame arriving while the buffer is held is tracked until its frame_end,
  // even if the held frame is released in the meantime.
  assign busy_zone = (state_reg == ST_HOLD) || ((state_reg == ST_IDLE) && busy_frm_reg);
  assign ram_wr_en = d_rdy && (state_reg == ST_PAYLOAD) && !ovf_reg;
  assign ram_rd_en = (state_reg == ST_HOLD) && rd_en && !frm_ack &&
                     (rd_ptr_reg != frm_len_reg);

  hsi_rx_frame_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_addr (AW'(wr_ptr_reg)),
    .wr_data (d),
    .rd_en   (ram_rd_en),
    .rd_addr (AW'(rd_ptr_reg)),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= 8'd0;
      flag_reg      <= 8'd0;
      errs_reg      <= 6'd0;
      byte_cnt_reg  <= 16'd0;
      ovf_reg       <= 1'b0;
      to_cnt_reg    <= '0;
      wr_ptr_reg    <= 8'd0;
      rd_ptr_reg    <= 8'd0;
      rd_zero_reg   <= 1'b0;
      busy_frm_reg  <= 1'b0;
      frm_valid_reg <= 1'b0;
      frm_flag_reg  <= 8'd0;
      frm_len_reg   <= 8'd0;
      err_vld_reg   <= 1'b0;
      err_code_reg  <= 3'd0;
      drop_cnt_reg  <= 8'd0;
      busy_reg      <= 1'b0;
    end else begin
      err_vld_reg <= 1'b0;

      if (in_frame) begin
        byte_cnt_reg <= cnt_next;
        if (d_rdy) begin
          to_cnt_reg <= '0;
        end else if (clk_en) begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (!busy_frm_reg && d_rdy) begin
            state_reg    <= ST_LEN;
            byte_cnt_reg <= 16'd1;
            to_cnt_reg   <= '0;
            ovf_reg      <= 1'b0;
            wr_ptr_reg   <= 8'd0;
            busy_reg     <= 1'b1;
          end
        end

        ST_LEN, ST_PAYLOAD, ST_TAIL: begin
          if (d_rdy && state_reg == ST_LEN) begin
            len_reg   <= d;
            ovf_reg   <= ({24'd0, d} > 32'(BUF_DEPTH));
            state_reg <= (d == 8'd0) ? ST_TAIL : ST_PAYLOAD;
          end
          if (d_rdy && state_reg == ST_PAYLOAD) begin
            if (!ovf_reg) begin
              wr_ptr_reg <= wr_ptr_reg + 8'd1;
            end
            if (cnt_next == len_ext + 16'd2) begin
              state_reg <= ST_TAIL;
            end
          end
          // frame_end overrides any byte-driven transition above
          if (frame_end) begin
            state_reg <= ST_CHECK;
            errs_reg  <= rx_errs;
            flag_reg  <= rx_flag;
          end else if (to_hit) begin
            state_reg    <= ST_DROP;
            err_vld_reg  <= 1'b1;
            err_code_reg <= DROP_TIMEOUT;
            drop_cnt_reg <= sat_inc8(drop_cnt_reg);
          end
        end

        ST_CHECK: begin
          if (errs_reg != 6'd0 || byte_cnt_reg != len_ext + 16'(FRM_OVH) || ovf_reg) begin
            state_reg    <= ST_DROP;
            err_vld_reg  <= 1'b1;
            drop_cnt_reg <= sat_inc8(drop_cnt_reg);
            if (errs_reg != 6'd0) begin
              err_code_reg <= DROP_RX_ERR;
            end else if (byte_cnt_reg != len_ext + 16'(FRM_OVH)) begin
              err_code_reg <= DROP_LEN;
            end else begin
              err_code_reg <= DROP_OVF;
            end
          end else begin
            state_reg     <= ST_HOLD;
            frm_valid_reg <= 1'b1;
            frm_flag_reg  <= flag_reg;
            frm_len_reg   <= len_reg;
            rd_ptr_reg    <= 8'd0;
          end
        end

        ST_HOLD: begin
          if (frm_ack) begin
            state_reg     <= ST_IDLE;
            frm_valid_reg <= 1'b0;
            rd_ptr_reg    <= 8'd0;
            wr_ptr_reg    <= 8'd0;
            busy_reg      <= 1'b0;
          end else if (rd_en) begin
            rd_zero_reg <= (rd_ptr_reg == frm_len_reg);
            if (rd_ptr_reg != frm_len_reg) begin
              rd_ptr_reg <= rd_ptr_reg + 8'd1;
            end
          end
        end

        ST_DROP: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (busy_zone) begin
        if (frame_end && (busy_frm_reg || d_rdy)) begin
          busy_frm_reg <= 1'b0;
          err_vld_reg  <= 1'b1;
          err_code_reg <= DROP_BUSY;
          drop_cnt_reg <= sat_inc8(drop_cnt_reg);
        end else if (d_rdy) begin
          busy_frm_reg <= 1'b1;
        end
      end
    end
  end

  assign frm_valid = frm_valid_reg;
  assign frm_flag  = frm_flag_reg;
  assign frm_len   = frm_len_reg;
  assign rd_data   = rd_zero_reg ? 8'd0 : ram_q;
  assign err_vld   = err_vld_reg;
  assign err_code  = err_code_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign busy      = busy_reg;

endmodule
